gray_counter_conv: RTL and testbench

- Parametrised WIDTH-bit Gray-code counter with a registered binary mirror.
- Gray code is used for clock-domain-crossing pointers and encoder tracking.
- An independent 1-cycle pipelined Gray-to-binary conversion channel replaces the earlier purely combinational 4-bit converter.
- Supports up/down count, parallel load in Gray, and wrap or saturate modes.

---
 rtl/gray_pkg.sv | 20 ++
 rtl/gray2bin_n.sv | 14 +
 rtl/gray_counter_conv.sv | 95 +++++++++
 tb/tb_gray_counter_conv.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared Gray/binary helpers. Functions operate on GRAY_MAX_W-bit words;
// callers zero-extend inputs and truncate results.
package gray_pkg;

    localparam int GRAY_MAX_W = 32;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
        logic [GRAY_MAX_W-1:0] b;
        b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational Gray-to-binary converter: each binary bit is the XOR of
// all Gray bits at or above its position.
module gray2bin_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin_o[i] = ^gray_i[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_counter_conv.sv
// Up/down Gray counter with registered binary mirror, Gray parallel load,
// wrap/saturate ends, plus an independent 1-cycle Gray-to-binary channel.
module gray_counter_conv
    import gray_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] gray_q,
    output logic [WIDTH-1:0] bin_q,
    output logic             tc,
    output logic             bound_o,
    input  logic             cv_valid_i,
    input  logic [WIDTH-1:0] cv_gray_i,
    output logic             cv_valid_o,
    output logic [WIDTH-1:0] cv_bin_o
);

    localparam logic [WIDTH-1:0] BIN_MAX = '1;
    localparam logic [WIDTH-1:0] BIN_MIN = '0;

    logic [WIDTH-1:0] load_bin;
    logic [WIDTH-1:0] cv_bin_d;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             bound_d;

    gray2bin_n #(.WIDTH(WIDTH)) u_load_conv (
        .gray_i (load_gray),
        .bin_o  (load_bin)
    );

    gray2bin_n #(.WIDTH(WIDTH)) u_cv_conv (
        .gray_i (cv_gray_i),
        .bin_o  (cv_bin_d)
    );

    always_comb begin
        bin_d   = bin_q;
        bound_d = 1'b0;
        if (load) begin
            bin_d = load_bin;
        end else if (en) begin
            if (dir) begin
                if (bin_q != BIN_MAX) begin
                    bin_d = bin_q + 1'b1;
                end else begin
                    bound_d = 1'b1;
                    if (WRAP) bin_d = BIN_MIN;
                end
            end else begin
                if (bin_q != BIN_MIN) begin
                    bin_d = bin_q - 1'b1;
                end else begin
                    bound_d = 1'b1;
                    if (WRAP) bin_d = BIN_MAX;
                end
            end
        end
    end

    // Gray is derived from the same next-state binary so both registers agree every cycle.
    assign gray_d = WIDTH'(bin2gray(GRAY_MAX_W'(bin_d)));

    assign tc = en & ((dir & (bin_q == BIN_MAX)) | (~dir & (bin_q == BIN_MIN)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q   <= '0;
            gray_q  <= '0;
            bound_o <= 1'b0;
        end else begin
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            bound_o <= bound_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_valid_o <= 1'b0;
            cv_bin_o   <= '0;
        end else begin
            cv_valid_o <= cv_valid_i;
            if (cv_valid_i) cv_bin_o <= cv_bin_d;
        end
    end

endmodule

// File: tb/tb_gray_counter_conv.sv
// Directed bench for gray_counter_conv: 4-bit wrap, 4-bit saturate and
// 16-bit instances sharing one clock and reset.
module tb_gray_counter_conv;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic       a_en, a_dir, a_load, a_cvv;
    logic [3:0] a_lg, a_cvg, a_gray, a_bin, a_cvb;
    logic       a_tc, a_bound, a_cvvo;

    logic       s_en, s_dir, s_load, s_cvv;
    logic [3:0] s_lg, s_cvg, s_gray, s_bin, s_cvb;
    logic       s_tc, s_bound, s_cvvo;

    logic        w_en, w_dir, w_load, w_cvv;
    logic [15:0] w_lg, w_cvg, w_gray, w_bin, w_cvb;
    logic        w_tc, w_bound, w_cvvo;

    int checks = 0;
    int errors = 0;

    gray_counter_conv #(.WIDTH(4), .WRAP(1'b1)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .dir(a_dir), .load(a_load), .load_gray(a_lg),
        .gray_q(a_gray), .bin_q(a_bin), .tc(a_tc), .bound_o(a_bound),
        .cv_valid_i(a_cvv), .cv_gray_i(a_cvg), .cv_valid_o(a_cvvo), .cv_bin_o(a_cvb));

    gray_counter_conv #(.WIDTH(4), .WRAP(1'b0)) u_s (
        .clk(clk), .rst_n(rst_n), .en(s_en), .dir(s_dir), .load(s_load), .load_gray(s_lg),
        .gray_q(s_gray), .bin_q(s_bin), .tc(s_tc), .bound_o(s_bound),
        .cv_valid_i(s_cvv), .cv_gray_i(s_cvg), .cv_valid_o(s_cvvo), .cv_bin_o(s_cvb));

    gray_counter_conv #(.WIDTH(16), .WRAP(1'b1)) u_w (
        .clk(clk), .rst_n(rst_n), .en(w_en), .dir(w_dir), .load(w_load), .load_gray(w_lg),
        .gray_q(w_gray), .bin_q(w_bin), .tc(w_tc), .bound_o(w_bound),
        .cv_valid_i(w_cvv), .cv_gray_i(w_cvg), .cv_valid_o(w_cvvo), .cv_bin_o(w_cvb));

    function automatic logic [15:0] ref_g2b(input logic [15:0] g);
        logic [15:0] b;
        b[15] = g[15];
        for (int i = 14; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a_en = 0; a_dir = 0; a_load = 0; a_cvv = 0; a_lg = '0; a_cvg = '0;
        s_en = 0; s_dir = 0; s_load = 0; s_cvv = 0; s_lg = '0; s_cvg = '0;
        w_en = 0; w_dir = 0; w_load = 0; w_cvv = 0; w_lg = '0; w_cvg = '0;
        #2;
        checks++;
        if ({a_gray, a_bin, a_bound, a_cvvo, a_cvb, a_tc} !== 15'd0) begin
            errors++;
            $display("FAIL reset_a got gray=%b bin=%b bound=%b cvv=%b cvb=%b tc=%b expected all 0",
                     a_gray, a_bin, a_bound, a_cvvo, a_cvb, a_tc);
        end
        checks++;
        if ({s_gray, s_bin, s_bound, s_cvvo, s_cvb} !== 14'd0) begin
            errors++;
            $display("FAIL reset_s got gray=%b bin=%b bound=%b expected 0", s_gray, s_bin, s_bound);
        end
        checks++;
        if ({w_gray, w_bin, w_cvb} !== 48'd0) begin
            errors++;
            $display("FAIL reset_w got gray=%h bin=%h cvb=%h expected 0", w_gray, w_bin, w_cvb);
        end
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_wrap_count();
        logic [3:0] gray4 [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111,
                                   4'b0101, 4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110,
                                   4'b1010, 4'b1011, 4'b1001, 4'b1000};
        logic [3:0] prev;
        a_en = 1; a_dir = 1;
        #1;
        for (int i = 0; i < 17; i++) begin
            checks++;
            if (a_tc !== (i == 15)) begin
                errors++;
                $display("FAIL wrap_tc step %0d got %b expected %b", i, a_tc, (i == 15));
            end
            prev = a_gray;
            step();
            checks++;
            if (a_gray !== gray4[(i+1)%16] || a_bin !== 4'((i+1)%16)) begin
                errors++;
                $display("FAIL wrap_count step %0d got gray=%b bin=%b expected gray=%b bin=%0d",
                         i, a_gray, a_bin, gray4[(i+1)%16], (i+1)%16);
            end
            checks++;
            if ($countones(prev ^ a_gray) != 1) begin
                errors++;
                $display("FAIL wrap_hamming step %0d got %b -> %b expected one-bit change", i, prev, a_gray);
            end
            checks++;
            if (a_bound !== (i == 15)) begin
                errors++;
                $display("FAIL wrap_bound step %0d got %b expected %b", i, a_bound, (i == 15));
            end
        end
        a_en = 0;
        step();
    endtask

    task automatic test_saturate();
        s_load = 1; s_lg = 4'b1000;
        step();
        s_load = 0; s_en = 1; s_dir = 1;
        #1;
        checks++;
        if (s_bin !== 4'b1111 || s_gray !== 4'b1000 || s_tc !== 1'b1) begin
            errors++;
            $display("FAIL sat_load got bin=%b gray=%b tc=%b expected 1111 1000 1", s_bin, s_gray, s_tc);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (s_bin !== 4'b1111 || s_gray !== 4'b1000 || s_bound !== 1'b1) begin
                errors++;
                $display("FAIL sat_hold cycle %0d got bin=%b gray=%b bound=%b expected 1111 1000 1",
                         i, s_bin, s_gray, s_bound);
            end
        end
        s_dir = 0;
        step();
        checks++;
        if (s_bin !== 4'b1110 || s_gray !== 4'b1001 || s_bound !== 1'b0) begin
            errors++;
            $display("FAIL sat_down got bin=%b gray=%b bound=%b expected 1110 1001 0", s_bin, s_gray, s_bound);
        end
        s_en = 0; s_load = 1; s_lg = 4'b0000;
        step();
        s_load = 0; s_en = 1; s_dir = 0;
        step();
        checks++;
        if (s_bin !== 4'b0000 || s_gray !== 4'b0000 || s_bound !== 1'b1) begin
            errors++;
            $display("FAIL sat_min got bin=%b gray=%b bound=%b expected 0000 0000 1", s_bin, s_gray, s_bound);
        end
        s_en = 0;
        step();
    endtask

    task automatic test_load_priority();
        a_load = 1; a_en = 1; a_dir = 1; a_lg = 4'b0110;
        step();
        checks++;
        if (a_bin !== 4'b0100 || a_gray !== 4'b0110 || a_bound !== 1'b0) begin
            errors++;
            $display("FAIL load_prio got bin=%b gray=%b bound=%b expected 0100 0110 0", a_bin, a_gray, a_bound);
        end
        a_en = 0; a_lg = 4'b0000;
        step();
        a_load = 0; a_en = 1; a_dir = 0;
        #1;
        checks++;
        if (a_tc !== 1'b1) begin
            errors++;
            $display("FAIL down_tc got %b expected 1", a_tc);
        end
        step();
        checks++;
        if (a_bin !== 4'b1111 || a_gray !== 4'b1000 || a_bound !== 1'b1) begin
            errors++;
            $display("FAIL down_wrap got bin=%b gray=%b bound=%b expected 1111 1000 1", a_bin, a_gray, a_bound);
        end
        a_en = 0;
        step();
    endtask

    task automatic test_conv();
        logic [3:0] gin  [3] = '{4'b1011, 4'b0111, 4'b1100};
        logic [3:0] bexp [3] = '{4'b1101, 4'b0101, 4'b1000};
        for (int i = 0; i < 3; i++) begin
            a_cvv = 1; a_cvg = gin[i];
            step();
            checks++;
            if (a_cvvo !== 1'b1 || a_cvb !== bexp[i]) begin
                errors++;
                $display("FAIL conv %0d got valid=%b bin=%b expected 1 %b", i, a_cvvo, a_cvb, bexp[i]);
            end
        end
        a_cvv = 0; a_cvg = 4'b0011;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if (a_cvvo !== 1'b0 || a_cvb !== 4'b1000) begin
                errors++;
                $display("FAIL conv_hold %0d got valid=%b bin=%b expected 0 1000", i, a_cvvo, a_cvb);
            end
        end
    endtask

    task automatic test_async_reset();
        a_load = 1; a_lg = 4'b0111;
        a_cvv = 1; a_cvg = 4'b1011;
        step();
        a_load = 0; a_en = 1; a_dir = 1;
        #2;
        checks++;
        if (a_bin !== 4'b0101 || a_cvvo !== 1'b1 || a_cvb !== 4'b1101) begin
            errors++;
            $display("FAIL pre_reset got bin=%b cvv=%b cvb=%b expected 0101 1 1101", a_bin, a_cvvo, a_cvb);
        end
        rst_n = 0;
        #1;
        checks++;
        if ({a_gray, a_bin, a_bound, a_cvvo, a_cvb, a_tc} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset got gray=%b bin=%b bound=%b cvv=%b cvb=%b tc=%b expected all 0",
                     a_gray, a_bin, a_bound, a_cvvo, a_cvb, a_tc);
        end
        step();
        checks++;
        if (a_bin !== 4'b0000 || a_cvvo !== 1'b0) begin
            errors++;
            $display("FAIL reset_held got bin=%b cvv=%b expected 0000 0", a_bin, a_cvvo);
        end
        rst_n = 1; a_cvv = 0;
        step();
        checks++;
        if (a_bin !== 4'b0001 || a_gray !== 4'b0001) begin
            errors++;
            $display("FAIL resume got bin=%b gray=%b expected 0001 0001", a_bin, a_gray);
        end
        a_en = 0;
        step();
    endtask

    task automatic test_wide();
        logic [15:0] lg, cg, eb;
        for (int i = 0; i < 20; i++) begin
            lg = 16'($urandom);
            cg = 16'($urandom);
            w_load = 1; w_lg = lg; w_cvv = 1; w_cvg = cg;
            step();
            eb = ref_g2b(lg);
            checks++;
            if (w_bin !== eb || w_gray !== lg || w_cvb !== ref_g2b(cg)) begin
                errors++;
                $display("FAIL wide_load %0d got bin=%h gray=%h cvb=%h expected %h %h %h",
                         i, w_bin, w_gray, w_cvb, eb, lg, ref_g2b(cg));
            end
            w_load = 0; w_cvv = 0; w_en = 1; w_dir = i[0];
            step();
            eb = i[0] ? eb + 16'd1 : eb - 16'd1;
            checks++;
            if (w_bin !== eb || w_gray !== (eb ^ (eb >> 1)) || w_cvb !== ref_g2b(cg)) begin
                errors++;
                $display("FAIL wide_step %0d got bin=%h gray=%h cvb=%h expected %h %h %h",
                         i, w_bin, w_gray, w_cvb, eb, eb ^ (eb >> 1), ref_g2b(cg));
            end
            w_en = 0;
        end
    endtask

    initial begin
        test_reset();
        test_wrap_count();
        test_saturate();
        test_load_priority();
        test_conv();
        test_async_reset();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
